// File: rtl/mem_steer.sv
// mem_steer: steers a single CPU memory access either to the boot ROM or to RAM.
//
// A request (cpu_rd / cpu_wr) is accepted only in IDLE. The address, the write data
// and the operation are latched. DECODE asks the ROM whether it claims the address.
// Claimed reads return ROM data. Claimed writes are silently dropped. Unclaimed
// accesses go to RAM, which is strobed until ram_done arrives or the timeout expires.
// ACK then pulses cpu_ack for one cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   cpu_addr/cpu_data_in  CPU request address / write data
//   cpu_rd/cpu_wr         CPU request strobes (read wins when both are set)
//   cpu_data_out          last captured read data (held between captures)
//   cpu_ack/bus_err       completion pulse / RAM-timeout flag (same cycle)
//   rom_addr/rom_rd       ROM address and read strobe
//   rom_data/rom_selected ROM read data and address-claim
//   ram_addr/ram_wdata    RAM address and write data
//   ram_rd/ram_wr         RAM strobes, held for the whole RAM phase
//   ram_rdata/ram_done    RAM read data and completion
module mem_steer #(
    parameter int unsigned RAM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_data_in,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [11:0] cpu_data_out,
    output logic        cpu_ack,
    output logic        bus_err,
    output logic [14:0] rom_addr,
    output logic        rom_rd,
    input  logic [11:0] rom_data,
    input  logic        rom_selected,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_wdata,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [11:0] ram_rdata,
    input  logic        ram_done
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StDecode = 2'd1;
    localparam logic [1:0] StRam    = 2'd2;
    localparam logic [1:0] StAck    = 2'd3;

    localparam int unsigned CW = $clog2(RAM_TIMEOUT + 1);
    // Count value in the last RAM cycle that may still complete normally.
    localparam logic [CW-1:0] CntLast = CW'(RAM_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [14:0]   addr_q, addr_d;
    logic [11:0]   wdata_q, wdata_d;
    logic          is_rd_q, is_rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_rd_d = is_rd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_rd || cpu_wr) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_data_in;
                    // Read has priority; a simultaneous write is discarded.
                    is_rd_d = cpu_rd;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                cnt_d = '0;
                if (rom_selected) begin
                    if (is_rd_q) begin
                        rdata_d = rom_data;
                    end
                    state_d = StAck;
                end else begin
                    state_d = StRam;
                end
            end
            StRam: begin
                if (ram_done) begin
                    if (is_rd_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CntLast) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            is_rd_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_rd_q <= is_rd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_data_out = rdata_q;
    assign cpu_ack      = (state_q == StAck);
    // err_q is only ever set on the transition into ACK, so it lasts exactly that cycle.
    assign bus_err      = err_q;
    assign rom_addr     = addr_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign rom_rd       = (state_q == StDecode) && is_rd_q;
    assign ram_rd       = (state_q == StRam) && is_rd_q;
    assign ram_wr       = (state_q == StRam) && !is_rd_q;

endmodule

// File: tb/tb_mem_steer.sv
module tb_mem_steer;

    localparam int TO  = 15;
    localparam int LEN = 90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] cpu_addr;
    logic [11:0] cpu_data_in;
    logic        cpu_rd, cpu_wr;
    logic [11:0] cpu_data_out;
    logic        cpu_ack, bus_err;
    logic [14:0] rom_addr, ram_addr;
    logic        rom_rd, rom_selected;
    logic [11:0] rom_data, ram_wdata, ram_rdata;
    logic        ram_rd, ram_wr, ram_done;

    mem_steer #(.RAM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n),
        .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack), .bus_err(bus_err),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .rom_selected(rom_selected),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
        .ram_rdata(ram_rdata), .ram_done(ram_done)
    );

    always #5 clk = ~clk;

    // Per-cycle stimulus.
    bit          s_rst[LEN];
    bit          s_rd[LEN], s_wr[LEN], s_rsel[LEN], s_done[LEN];
    logic [14:0] s_addr[LEN];
    logic [11:0] s_din[LEN], s_rdat[LEN], s_mdat[LEN];
    // Per-cycle expectations.
    bit          e_ack[LEN], e_err[LEN], e_rom_rd[LEN], e_ram_rd[LEN], e_ram_wr[LEN];
    bit          e_addr_v[LEN];
    logic [14:0] e_addr[LEN];
    logic [11:0] e_wdata[LEN], e_data[LEN];

    int n_chk  = 0;
    int n_pass = 0;
    int cur    = 0;
    bit fin    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0o expected %0o", name, cur, act, exp);
    endtask

    task automatic data_from(input int k, input logic [11:0] v);
        for (int j = k; j < LEN; j++) e_data[j] = v;
    endtask

    // One CPU access issued in cycle n. w = RAM wait cycles before done, -1 = never.
    task automatic add_txn(input int n, input bit rd, input bit wr, input logic [14:0] a,
                           input logic [11:0] d, input bit rsel, input logic [11:0] rdat,
                           input int w, input logic [11:0] mdat);
        int ack;
        bit op_rd;
        op_rd = rd;
        s_rd[n] = rd; s_wr[n] = wr; s_addr[n] = a; s_din[n] = d;
        s_rsel[n+1] = rsel; s_rdat[n+1] = rdat;
        e_rom_rd[n+1] = op_rd;
        if (rsel) begin
            ack = n + 2;
            if (op_rd) data_from(ack, rdat);
        end else begin
            if (w >= 0 && w < TO) begin
                ack = n + 3 + w;
                s_done[n+2+w] = 1'b1;
                s_mdat[n+2+w] = mdat;
                if (op_rd) data_from(ack, mdat);
            end else begin
                ack = n + 2 + TO;
                e_err[ack] = 1'b1;
                data_from(ack, 12'o0);
            end
            for (int j = n + 2; j < ack; j++) begin
                e_ram_rd[j] = op_rd;
                e_ram_wr[j] = !op_rd;
            end
        end
        e_ack[ack] = 1'b1;
        for (int j = n + 1; j <= ack; j++) begin
            e_addr_v[j] = 1'b1; e_addr[j] = a; e_wdata[j] = d;
        end
    endtask

    // Reset held low for len cycles from r; whatever was in flight is forgotten.
    task automatic add_reset(input int r, input int len);
        for (int j = r; j < LEN; j++) begin
            e_ack[j] = 0; e_err[j] = 0; e_rom_rd[j] = 0; e_ram_rd[j] = 0; e_ram_wr[j] = 0;
            e_addr_v[j] = 0;
        end
        data_from(r, 12'o0);
        for (int j = r; j < r + len; j++) begin
            s_rst[j] = 1'b0; e_addr_v[j] = 1'b1; e_addr[j] = 15'o0;
        end
    endtask

    task automatic apply(input int c);
        rst_n = s_rst[c]; cpu_rd = s_rd[c]; cpu_wr = s_wr[c];
        cpu_addr = s_addr[c]; cpu_data_in = s_din[c];
        rom_selected = s_rsel[c]; rom_data = s_rdat[c];
        ram_done = s_done[c]; ram_rdata = s_mdat[c];
    endtask

    always @(negedge clk) begin
        if (cur > 0 && !fin) begin
            chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[cur]));
            chk("bus_err", 32'(bus_err), 32'(e_err[cur]));
            chk("rom_rd", 32'(rom_rd), 32'(e_rom_rd[cur]));
            chk("ram_rd", 32'(ram_rd), 32'(e_ram_rd[cur]));
            chk("ram_wr", 32'(ram_wr), 32'(e_ram_wr[cur]));
            chk("cpu_data_out", 32'(cpu_data_out), 32'(e_data[cur]));
            if (e_addr_v[cur]) begin
                chk("rom_addr", 32'(rom_addr), 32'(e_addr[cur]));
                chk("ram_addr", 32'(ram_addr), 32'(e_addr[cur]));
            end
            if (e_ram_wr[cur]) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata[cur]));
            // Hand-computed anchors.
            case (cur)
                1:  chk("lit_reset_data", 32'(cpu_data_out), 32'o0);
                6:  chk("lit_rom_read", {19'b0, cpu_ack, cpu_data_out}, {19'b0, 1'b1, 12'o7240});
                15: chk("lit_ram_read", {19'b0, cpu_ack, cpu_data_out}, {19'b0, 1'b1, 12'o1234});
                19: chk("lit_rom_write", {19'b0, cpu_ack, cpu_data_out}, {19'b0, 1'b1, 12'o1234});
                38: chk("lit_timeout", {18'b0, cpu_ack, bus_err, cpu_data_out},
                        {18'b0, 1'b1, 1'b1, 12'o0});
                49: chk("lit_reset_abort", {29'b0, cpu_ack, ram_rd, ram_wr}, 32'd0);
                57: chk("lit_after_reset", {19'b0, cpu_ack, cpu_data_out}, {19'b0, 1'b1, 12'o2525});
                77: chk("lit_last_wait", {18'b0, cpu_ack, bus_err, cpu_data_out},
                        {18'b0, 1'b1, 1'b0, 12'o6060});
                default: ;
            endcase
        end
    end

    initial begin
        for (int j = 0; j < LEN; j++) begin
            s_rst[j] = 1'b1; s_rd[j] = 0; s_wr[j] = 0; s_rsel[j] = 0; s_done[j] = 0;
            s_addr[j] = 15'o0; s_din[j] = 12'o0; s_rdat[j] = 12'o1111; s_mdat[j] = 12'o3333;
            e_ack[j] = 0; e_err[j] = 0; e_rom_rd[j] = 0; e_ram_rd[j] = 0; e_ram_wr[j] = 0;
            e_addr_v[j] = 0; e_addr[j] = 15'o0; e_wdata[j] = 12'o0; e_data[j] = 12'o0;
        end
        add_reset(0, 2);
        // ROM read; stray ram_done in DECODE/ACK and a request held during ACK are ignored.
        add_txn(4, 1, 0, 15'o07400, 12'o0, 1, 12'o7240, 0, 12'o0);
        s_done[5] = 1'b1; s_done[6] = 1'b1;
        s_rd[6] = 1'b1; s_addr[6] = 15'o01234;
        // ROM deactivated -> RAM read with 3 waits; stray done in DECODE.
        add_txn(9, 1, 0, 15'o07400, 12'o0, 0, 12'o0, 3, 12'o1234);
        s_done[10] = 1'b1;
        // Write into ROM space is dropped.
        add_txn(17, 0, 1, 15'o07410, 12'o5555, 1, 12'o0, 0, 12'o0);
        // RAM write that never completes.
        add_txn(21, 0, 1, 15'o00100, 12'o0017, 0, 12'o0, -1, 12'o0);
        // Read and write together, zero-wait RAM.
        add_txn(40, 1, 1, 15'o00200, 12'o4321, 0, 12'o0, 0, 12'o0707);
        // RAM read aborted by reset.
        add_txn(45, 1, 0, 15'o00300, 12'o0, 0, 12'o0, 5, 12'o7070);
        add_reset(49, 2);
        add_txn(53, 1, 0, 15'o00400, 12'o0, 0, 12'o0, 1, 12'o2525);
        // Done in the very last cycle before the timeout would fire.
        add_txn(60, 1, 0, 15'o01000, 12'o0, 0, 12'o0, TO - 1, 12'o6060);

        apply(0);
        for (int c = 1; c < LEN; c++) begin
            @(posedge clk);
            #1;
            cur = c;
            apply(c);
        end
        @(negedge clk);
        #1;
        fin = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_steer.md
MEM_STEER -- requirements
Module: mem_steer

Interface
REQ-001 Parameter RAM_TIMEOUT, default 15, RAM-phase cycles without ram_done before the access is aborted.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 cpu_addr  input  15  CPU memory address (field + 12-bit address).
REQ-005 cpu_data_in  input  12  CPU write data.
REQ-006 cpu_rd  input  1  CPU read request, sampled in IDLE only.
REQ-007 cpu_wr  input  1  CPU write request, sampled in IDLE only.
REQ-008 cpu_data_out  output  12  read data, valid while cpu_ack=1.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 bus_err  output  1  one-cycle pulse coincident with cpu_ack on RAM timeout.
REQ-011 rom_addr  output  15  latched address to boot ROM.
REQ-012 rom_rd  output  1  ROM read strobe.
REQ-013 rom_data  input  12  ROM read data, combinational from rom_addr.
REQ-014 rom_selected  input  1  ROM claims rom_addr (active and in 7400-7577).
REQ-015 ram_addr  output  15  latched address to RAM.
REQ-016 ram_wdata  output  12  latched write data to RAM.
REQ-017 ram_rd  output  1  RAM read strobe, held through the RAM phase.
REQ-018 ram_wr  output  1  RAM write strobe, held through the RAM phase.
REQ-019 ram_rdata  input  12  RAM read data, valid when ram_done=1.
REQ-020 ram_done  input  1  RAM completion, sampled during the RAM phase.

Function
REQ-021 States SHALL be IDLE, DECODE, RAM, ACK; reset state IDLE.
REQ-022 IDLE: cpu_rd or cpu_wr high SHALL latch cpu_addr, cpu_data_in and op into registers and go to DECODE; with both high, read SHALL win and the write SHALL be discarded.
REQ-023 rom_addr and ram_addr SHALL both equal the latched address in all non-IDLE states.
REQ-024 DECODE: rom_rd SHALL be 1 for a latched read.
REQ-025 DECODE read with rom_selected=1 SHALL capture rom_data into cpu_data_out and go to ACK.
REQ-026 DECODE write with rom_selected=1 SHALL be dropped (no ram_wr, ever) and go to ACK.
REQ-027 DECODE with rom_selected=0 SHALL go to RAM.
REQ-028 RAM: ram_rd (read) or ram_wr (write) SHALL be 1 every cycle in RAM, 0 in all other states.
REQ-029 RAM: ram_done=1 SHALL go to ACK, capturing ram_rdata on reads; done in the first RAM cycle is legal (zero wait).
REQ-030 RAM-phase counter SHALL clear on entry and increment each RAM cycle without done; reaching RAM_TIMEOUT SHALL go to ACK with cpu_data_out=0000 and bus_err=1 in the ACK cycle.
REQ-031 ACK: cpu_ack=1 for exactly one cycle, then IDLE; requests are not sampled in ACK.
REQ-032 cpu_data_out SHALL hold its value until the next capture; writes SHALL leave it unchanged.
REQ-033 Latency: request sampled in cycle N -> ROM access acks in N+2; RAM access acks in N+3+W, where W = wait cycles before ram_done.
REQ-034 ram_done outside the RAM state SHALL be ignored.

Reset
REQ-035 With reset=0, asynchronously: state IDLE; cpu_data_out=0000; cpu_ack, bus_err, rom_rd, ram_rd, ram_wr=0; latched address/data and counter=0.
REQ-036 Reset mid-access SHALL abort it with no cpu_ack; the first request after reset release SHALL be sampled normally.

Verification
REQ-037 Read 07400, rom_selected=1, rom_data=7240 -> rom_rd in DECODE, cpu_ack in N+2, cpu_data_out=7240, ram_rd never.
REQ-038 Read 07400 with rom_selected=0 (ROM deactivated), ram_done after 3 waits, ram_rdata=1234 -> ram_rd 4 cycles, ack N+6, data 1234.
REQ-039 Write 5555 to 07410, rom_selected=1 -> ack N+2, ram_wr never, cpu_data_out unchanged.
REQ-040 Write 0017 to 00100, ram_done never -> ram_wr for 15 cycles, cpu_ack and bus_err together, cpu_data_out=0000.
REQ-041 cpu_rd and cpu_wr both high, address 00200 -> ram_rd only, ram_wr never.
REQ-042 reset=0 during RAM phase -> outputs zero immediately, no ack; a new read after release completes normally.
